// File: rtl/cdb_pkg.sv
// Shared definitions for the CDB scheduler: source-select encoding, slot
// control struct and the default tag width.
package cdb_pkg;

   localparam int CDB_TAG_W = 6;

   localparam logic [1:0] CDB_INT  = 2'b00;
   localparam logic [1:0] CDB_LD   = 2'b01;
   localparam logic [1:0] CDB_MULT = 2'b10;
   localparam logic [1:0] CDB_DIV  = 2'b11;

   // Control half of a slot entry; the tag is kept in a parallel array so its
   // width can follow the TAG_W parameter of the instantiating module.
   typedef struct packed {
      logic       valid;
      logic [1:0] sel;
   } slot_ctrl_t;

endpackage

// File: rtl/cdb_slot_pipe.sv
// Reservation pipeline indexed by future CDB cycle. Entry i holds the result
// that will be on the CDB i cycles after the current one. Grants are merged
// into a combinational view, the head of that view is handed to the CDB
// register, and the rest of the view shifts down one entry per clock.
module cdb_slot_pipe
   import cdb_pkg::*;
#(
   parameter int TAG_W    = CDB_TAG_W,
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             near_ins,
   input  logic [1:0]       near_sel,
   input  logic [TAG_W-1:0] near_tag,
   input  logic             mult_ins,
   input  logic [TAG_W-1:0] mult_tag,
   input  logic             div_ins,
   input  logic [TAG_W-1:0] div_tag,
   output logic             near_busy,
   output logic             mult_busy,
   output logic             head_valid,
   output logic [1:0]       head_sel,
   output logic [TAG_W-1:0] head_tag
);

   slot_ctrl_t       ctrl_q [1:DIV_LAT];
   logic [TAG_W-1:0] tag_q  [1:DIV_LAT];
   slot_ctrl_t       ctrl_v [1:DIV_LAT];
   logic [TAG_W-1:0] tag_v  [1:DIV_LAT];

   // Merge this cycle's grants into the current slot contents.
   always_comb begin
      for (int i = 1; i <= DIV_LAT; i++) begin
         ctrl_v[i] = ctrl_q[i];
         tag_v[i]  = tag_q[i];
      end
      if (near_ins) begin
         ctrl_v[1] = '{valid: 1'b1, sel: near_sel};
         tag_v[1]  = near_tag;
      end
      if (mult_ins) begin
         ctrl_v[MULT_LAT] = '{valid: 1'b1, sel: CDB_MULT};
         tag_v[MULT_LAT]  = mult_tag;
      end
      if (div_ins) begin
         ctrl_v[DIV_LAT] = '{valid: 1'b1, sel: CDB_DIV};
         tag_v[DIV_LAT]  = div_tag;
      end
   end

   // Advance one CDB cycle; entry 1 of the view leaves through the head port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i <= DIV_LAT; i++) begin
            ctrl_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         for (int i = 1; i < DIV_LAT; i++) begin
            ctrl_q[i] <= ctrl_v[i+1];
            tag_q[i]  <= tag_v[i+1];
         end
         ctrl_q[DIV_LAT] <= '0;
         tag_q[DIV_LAT]  <= '0;
      end
   end

   // Occupancy of the slots each unit class would land in if granted now.
   always_comb begin
      near_busy  = ctrl_q[1].valid;
      mult_busy  = ctrl_q[MULT_LAT].valid;
      head_valid = ctrl_v[1].valid;
      head_sel   = ctrl_v[1].sel;
      head_tag   = tag_v[1];
   end

endmodule

// File: rtl/cdb_scheduler.sv
// CDB arbiter for the int, load, mult and div units. A unit is granted only
// when its fixed latency lands on a free CDB cycle; the registered CDB
// valid/tag/sel drive the writeback mux in the issue stage.
module cdb_scheduler
   import cdb_pkg::*;
#(
   parameter int TAG_W    = CDB_TAG_W,
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_int,
   input  logic             req_ld,
   input  logic             req_mult,
   input  logic             req_div,
   input  logic [TAG_W-1:0] tag_int,
   input  logic [TAG_W-1:0] tag_ld,
   input  logic [TAG_W-1:0] tag_mult,
   input  logic [TAG_W-1:0] tag_div,
   output logic             grant_int,
   output logic             grant_ld,
   output logic             grant_mult,
   output logic             grant_div,
   output logic             div_busy,
   output logic             cdb_valid,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [1:0]       cdb_sel
);

   localparam int CNT_W = $clog2(DIV_LAT);

   logic             lru_q, lru_d;  // 0: int is least recently used
   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic             near_busy, mult_busy;
   logic             near_free, contested;
   logic             near_ins;
   logic [1:0]       near_sel;
   logic [TAG_W-1:0] near_tag;
   logic             head_valid;
   logic [1:0]       head_sel;
   logic [TAG_W-1:0] head_tag;

   cdb_slot_pipe #(
      .TAG_W    (TAG_W),
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_slot_pipe (
      .clk        (clk),
      .reset      (reset),
      .near_ins   (near_ins),
      .near_sel   (near_sel),
      .near_tag   (near_tag),
      .mult_ins   (grant_mult),
      .mult_tag   (tag_mult),
      .div_ins    (grant_div),
      .div_tag    (tag_div),
      .near_busy  (near_busy),
      .mult_busy  (mult_busy),
      .head_valid (head_valid),
      .head_sel   (head_sel),
      .head_tag   (head_tag)
   );

   // Grant decision from requests and registered slot state only; held low
   // during reset so nothing issues while the pipeline is being cleared.
   always_comb begin
      div_busy   = |div_cnt_q;
      grant_div  = ~reset & req_div & ~div_busy;
      grant_mult = ~reset & req_mult & ~mult_busy;
      near_free  = ~reset & ~near_busy;
      contested  = near_free & req_int & req_ld;
      grant_int  = near_free & req_int & (~req_ld | ~lru_q);
      grant_ld   = near_free & req_ld & (~req_int | lru_q);
      near_ins   = grant_int | grant_ld;
      near_sel   = grant_ld ? CDB_LD : CDB_INT;
      near_tag   = grant_ld ? tag_ld : tag_int;
   end

   // LRU moves to the loser only when int and ld actually competed.
   always_comb begin
      lru_d = lru_q;
      if (contested) begin
         lru_d = grant_int;
      end
   end

   // Divider occupancy: busy until the cycle its result reaches the CDB.
   always_comb begin
      div_cnt_d = div_cnt_q;
      if (grant_div) begin
         div_cnt_d = CNT_W'(DIV_LAT - 1);
      end else if (div_busy) begin
         div_cnt_d = div_cnt_q - CNT_W'(1);
      end
   end

   // Scheduler state and registered CDB outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lru_q     <= 1'b0;
         div_cnt_q <= '0;
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_sel   <= CDB_INT;
      end else begin
         lru_q     <= lru_d;
         div_cnt_q <= div_cnt_d;
         cdb_valid <= head_valid;
         cdb_tag   <= head_tag;
         cdb_sel   <= head_sel;
      end
   end

endmodule
